// File: rtl/cci_mpf_shim_vtp_tlb_assoc_if.sv
// cci_mpf_shim_vtp_tlb_assoc_if: lookup, fill and invalidate signals between VTP clients/walker and the TLB
interface cci_mpf_shim_vtp_tlb_assoc_if #(
  parameter int NUM_PORTS = 2,
  parameter int VA_IDX_BITS = 36,
  parameter int PA_IDX_BITS = 26
);
  logic lookup_en [NUM_PORTS];
  logic [VA_IDX_BITS-1:0] lookup_page_va [NUM_PORTS];
  logic lookup_rdy [NUM_PORTS];
  logic lookup_valid [NUM_PORTS];
  logic [PA_IDX_BITS-1:0] lookup_rsp_page_pa [NUM_PORTS];
  logic lookup_is_big_page [NUM_PORTS];
  logic lookup_miss [NUM_PORTS];
  logic [VA_IDX_BITS-1:0] lookup_miss_va [NUM_PORTS];
  logic fill_en;
  logic [VA_IDX_BITS-1:0] fill_va;
  logic [PA_IDX_BITS-1:0] fill_pa;
  logic fill_rdy;
  logic inval_en;
  logic [VA_IDX_BITS-1:0] inval_va;
  logic inval_all;
  modport master (
    output lookup_en, lookup_page_va, fill_en, fill_va, fill_pa, inval_en, inval_va, inval_all,
    input lookup_rdy, lookup_valid, lookup_rsp_page_pa, lookup_is_big_page, lookup_miss, lookup_miss_va, fill_rdy
  );
  modport slave (
    input lookup_en, lookup_page_va, fill_en, fill_va, fill_pa, inval_en, inval_va, inval_all,
    output lookup_rdy, lookup_valid, lookup_rsp_page_pa, lookup_is_big_page, lookup_miss, lookup_miss_va, fill_rdy
  );
endinterface

// File: rtl/cci_mpf_shim_vtp_tlb_assoc.sv
// cci_mpf_shim_vtp_tlb_assoc: set-associative TLB with NUM_PORTS two-cycle lookup ports and a fill/invalidate pipeline
module cci_mpf_shim_vtp_tlb_assoc #(
  parameter int NUM_PORTS = 2,
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 64,
  parameter int BIG_PAGES = 0,
  parameter int VA_IDX_BITS = 36,
  parameter int PA_IDX_BITS = 26
) (
  input logic clk,
  input logic reset,
  cci_mpf_shim_vtp_tlb_assoc_if.slave io
);
  localparam int LO = BIG_PAGES != 0 ? 9 : 0;
  localparam int SB = $clog2(NUM_SETS);
  localparam int WB = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;
  localparam int TB = VA_IDX_BITS - LO - SB;
  localparam int PB = PA_IDX_BITS - LO;
  localparam logic [PA_IDX_BITS-1:0] LMASK = PA_IDX_BITS'((1 << LO) - 1);

  typedef enum logic [2:0] {INIT, RUN, FILL_RD, FILL_WR, FLUSH} state_t;

  logic [TB-1:0] tag_mem [NUM_WAYS][NUM_SETS];
  logic [PB-1:0] pa_mem [NUM_WAYS][NUM_SETS];
  logic val_mem [NUM_WAYS][NUM_SETS];
  logic [WB-1:0] vic_mem [NUM_SETS];

  state_t state;
  logic [SB-1:0] cnt;
  logic rdy_lk, rdy_fl;
  logic f_inval, hit_r, bump_r;
  logic [VA_IDX_BITS-1:0] f_va;
  logic [PA_IDX_BITS-1:0] f_pa;
  logic [WB-1:0] way_r, f_sel;
  logic f_bump, f_any;
  logic [SB-1:0] f_set;
  logic [TB-1:0] f_tag;

  assign f_set = f_va[LO +: SB];
  assign f_tag = f_va[LO+SB +: TB];
  assign io.fill_rdy = rdy_fl;

  // Preference order: way already holding the tag, lowest invalid way, victim pointer
  always_comb begin
    f_sel = vic_mem[f_set];
    f_bump = 1'b1;
    f_any = 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!val_mem[w][f_set]) begin
        f_sel = WB'(w);
        f_bump = 1'b0;
      end
    for (int w = 0; w < NUM_WAYS; w++)
      if (val_mem[w][f_set] && tag_mem[w][f_set] == f_tag) begin
        f_sel = WB'(w);
        f_bump = 1'b0;
        f_any = 1'b1;
      end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      cnt <= '0;
      rdy_lk <= 1'b0;
      rdy_fl <= 1'b0;
      f_inval <= 1'b0;
      hit_r <= 1'b0;
      bump_r <= 1'b0;
      way_r <= '0;
      f_va <= '0;
      f_pa <= '0;
    end else begin
      case (state)
        INIT, FLUSH: begin
          for (int w = 0; w < NUM_WAYS; w++) val_mem[w][cnt] <= 1'b0;
          vic_mem[cnt] <= '0;
          cnt <= cnt + 1'b1;
          if (cnt == SB'(NUM_SETS - 1)) begin
            state <= RUN;
            rdy_lk <= 1'b1;
            rdy_fl <= 1'b1;
          end
        end
        RUN: begin
          if (io.inval_all) begin
            state <= FLUSH;
            rdy_lk <= 1'b0;
            rdy_fl <= 1'b0;
          end else if (io.inval_en || io.fill_en) begin
            state <= FILL_RD;
            rdy_fl <= 1'b0;
            f_inval <= io.inval_en;
            f_va <= io.inval_en ? io.inval_va : io.fill_va;
            f_pa <= io.fill_pa;
          end
        end
        FILL_RD: begin
          state <= FILL_WR;
          way_r <= f_sel;
          hit_r <= f_any;
          bump_r <= f_bump;
        end
        FILL_WR: begin
          state <= RUN;
          rdy_fl <= 1'b1;
          if (!f_inval || hit_r) val_mem[way_r][f_set] <= !f_inval;
          if (!f_inval && bump_r)
            vic_mem[f_set] <= vic_mem[f_set] == WB'(NUM_WAYS - 1) ? '0 : vic_mem[f_set] + 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == FILL_WR && !f_inval) begin
      tag_mem[way_r][f_set] <= f_tag;
      pa_mem[way_r][f_set] <= f_pa[LO +: PB];
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic v1, valid_r, miss_r, big_r, any;
    logic [VA_IDX_BITS-1:0] va1, miss_va_r;
    logic [PA_IDX_BITS-1:0] rsp_r;
    logic [PB-1:0] pa_st;
    logic [SB-1:0] set1;
    assign set1 = va1[LO +: SB];
    // Combinational read in T1 sees the array before any same-cycle fill write lands
    always_comb begin
      pa_st = '0;
      any = 1'b0;
      for (int w = 0; w < NUM_WAYS; w++)
        if (val_mem[w][set1] && tag_mem[w][set1] == va1[LO+SB +: TB]) begin
          pa_st = pa_st | pa_mem[w][set1];
          any = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        v1 <= 1'b0;
        va1 <= '0;
        valid_r <= 1'b0;
        miss_r <= 1'b0;
        big_r <= 1'b0;
        rsp_r <= '0;
        miss_va_r <= '0;
      end else begin
        v1 <= io.lookup_en[p] && rdy_lk;
        va1 <= io.lookup_page_va[p];
        valid_r <= v1 && any;
        miss_r <= v1 && !any;
        big_r <= v1 && any && BIG_PAGES != 0;
        rsp_r <= v1 && any ? (PA_IDX_BITS'(pa_st) << LO) | (PA_IDX_BITS'(va1[8:0]) & LMASK) : rsp_r;
        miss_va_r <= v1 && !any ? va1 : miss_va_r;
      end
    end
    assign io.lookup_rdy[p] = rdy_lk;
    assign io.lookup_valid[p] = valid_r;
    assign io.lookup_miss[p] = miss_r;
    assign io.lookup_is_big_page[p] = big_r;
    assign io.lookup_rsp_page_pa[p] = rsp_r;
    assign io.lookup_miss_va[p] = miss_va_r;
  end
endmodule

// File: doc/cci_mpf_shim_vtp_tlb_assoc.md
# cci_mpf_shim_vtp_tlb_assoc

Parametrised set-associative TLB server for the VTP pipeline. It provides NUM_PORTS independent lookup ports with fixed two-cycle latency, a fill port and an invalidate port. It holds either 4KB or 2MB translations, selected by parameter, and always speaks in 4KB page indices. It sits between the VTP request pipeline (lookup clients) and the page table walker (fill and invalidate master), replacing the fixed two-port TLB.

## Interface
- NUM_PORTS, 2: number of independent lookup ports (1–4).
- NUM_WAYS, 4: associativity (power of 2, 1–8).
- NUM_SETS, 64: sets per way (power of 2, ≥2).
- BIG_PAGES, 0: 0 = 4KB entries, 1 = 2MB entries.
- VA_IDX_BITS, 36: 4KB VA page-index width.
- PA_IDX_BITS, 26: 4KB PA page-index width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- lookupEn[p]  in  1  lookup request; accepted when lookupRdy[p]=1.
- lookupPageVA[p]  in  VA_IDX_BITS  VA page index for the lookup.
- lookupRdy[p]  out  1  port can accept a lookup.
- lookupValid[p]  out  1  hit, asserted exactly 2 cycles after an accepted lookup.
- lookupRspPagePA[p]  out  PA_IDX_BITS  translated PA page index; meaningful only when lookupValid[p]=1.
- lookupIsBigPage[p]  out  1  equals BIG_PAGES on a hit.
- lookupMiss[p]  out  1  miss pulse, 2 cycles after the accepted lookup.
- lookupMissVA[p]  out  VA_IDX_BITS  VA of the missing lookup.
- fillEn  in  1  insert a translation; accepted when fillRdy=1.
- fillVA  in  VA_IDX_BITS  VA page index of the new translation.
- fillPA  in  PA_IDX_BITS  PA page index of the new translation.
- fillRdy  out  1  fill and invalidate pipeline is idle.
- invalEn  in  1  invalidate one VA; accepted when fillRdy=1.
- invalVA  in  VA_IDX_BITS  VA page index to invalidate.
- invalAll  in  1  flush every entry; accepted when fillRdy=1.

## Operation
- **Page-index slicing.** Let SB = log2(NUM_SETS) and LO = BIG_PAGES ? 9 : 0.
  - set = va[LO +: SB]
  - tag = va[VA_IDX_BITS-1 : LO+SB]
  - stored PA = pa[PA_IDX_BITS-1 : LO]
  - Low 9 bits of fillVA and fillPA are ignored when BIG_PAGES=1.
- **Entry contents:** valid, tag, stored PA. Each set also holds a round-robin victim pointer of log2(NUM_WAYS) bits.
- **FSM states:** INIT, RUN, FILL_RD, FILL_WR, FLUSH.
  - Reset → INIT. INIT walks a set counter from 0 to NUM_SETS-1, clearing all valid bits and victim pointers; it takes NUM_SETS cycles and then goes to RUN.
  - RUN accepts fill, invalidate or invalAll. Priority is invalAll > invalEn > fillEn; only one is accepted per cycle, and a non-accepted request must be held by the master.
  - fill or inval: RUN → FILL_RD (read target set) → FILL_WR (write) → RUN.
  - invalAll: RUN → FLUSH, which clears all sets like INIT (NUM_SETS cycles) and returns to RUN.
- **Fill write rule.**
  - If the tag already hits in a way, that way is overwritten and there is no duplicate.
  - Otherwise the lowest-index invalid way is used.
  - Otherwise the way at the victim pointer is used, and the pointer increments mod NUM_WAYS.
- **Invalidate rule:** clears valid on the matching way. There is no effect on a miss.
- **Lookup pipeline** (per port, fully pipelined, one lookup per port per cycle):
  - T0: accept.
  - T1: read the set.
  - T2: compare tags and drive registered outputs.
  - Hit: lookupValid=1 and lookupRspPagePA = {stored PA, BIG_PAGES ? va[8:0] : none}.
  - Miss: lookupMiss=1 and lookupMissVA = VA.
  - Exactly one of lookupValid or lookupMiss pulses per accepted lookup.
- **Hazards:** the array reads old data on a read/write collision in the same cycle. A lookup whose T1 coincides with FILL_WR to the same set sees pre-write contents. A lookup accepted in the FILL_WR cycle or later sees the new entry.
- **Multiple hits** in one set cannot occur by construction; the bench must flag one as an error.

## Timing
- **Reset values:** all lookupValid=0, lookupMiss=0, lookupRdy=0, fillRdy=0. lookupRspPagePA, lookupMissVA and lookupIsBigPage are 0.
- **Lookup readiness:** lookupRdy[p]=1 only in RUN, FILL_RD and FILL_WR. It is 0 in INIT and FLUSH.
- **Fill readiness:** fillRdy=1 only in RUN.
  - First fillRdy and lookupRdy occur NUM_SETS cycles after reset deasserts.
  - Fill-to-fill throughput is 1 per 3 cycles.
- **Lookup latency:** fixed at 2 cycles. There is no back-pressure on responses.
- **Flush behaviour:** lookups in flight when FLUSH begins complete using pre-flush contents for T1 reads before the first clear cycle.
- **Reset mid-operation:** all in-flight lookups and fills are dropped, no response pulses appear after reset, and the block returns to INIT.

## Test plan
- **Reset/init:** assert reset 1 cycle with NUM_SETS=64 → lookupRdy and fillRdy rise exactly 64 cycles after reset deasserts; a lookup of VA 0x123 then gives lookupMiss=1 and lookupMissVA=0x123 at T+2.
- **Fill then hit, 4KB mode:** fill VA 0x00A5, PA 0x3C1 → a lookup on port 1 of 0x00A5 three cycles later gives lookupValid=1, PA 0x3C1, lookupIsBigPage=0; a lookup of 0x00A6 misses.
- **2MB mode:** fill VA 0x400, PA 0x1200 → lookup of VA 0x5FF gives hit, PA 0x13FF, lookupIsBigPage=1; lookup of VA 0x600 misses.
- **Replacement:** NUM_WAYS=4, fill 5 distinct VAs mapping to set 3 → the first VA misses and the other four hit; refilling an existing VA with a new PA returns the new PA with no eviction.
- **Invalidate/flush:** invalEn on a resident VA → miss afterwards while the others still hit; invalAll → fillRdy=0 for 64 cycles, then every prior VA misses.
- **Collision and reset mid-op:** a lookup to the same set in the FILL_RD cycle misses, and one issued in the FILL_WR cycle hits; reset asserted at T1 of a lookup → no lookupValid or lookupMiss pulse follows.
